fir_seq_ctrl: RTL and testbench
===============================

// Module: fir_seq_ctrl
// PURPOSE
//   Sequencer for the 11-tap FIR engine: owns the ap_start/ap_done/ap_idle protocol,
//   the AXI-Stream in/out handshakes and all compute-side addressing of the tap and data bram11.
//   Zeroes the data RAM, writes each input sample into a circular 11-entry buffer, then
//   issues 11 tap/data reads and MAC strobes to the external multiply-accumulate datapath.
// PARAMETERS
//   pADDR_WIDTH  12  BRAM byte-address width
//   pDATA_WIDTH  32  sample/coefficient width
//   Tape_Num     11  taps = data-buffer depth
// PORTS
//   axis_clk     in   1   single clock
//   axis_rst_n   in   1   asynchronous, active-low reset
//   start_req    in   1   1-cycle pulse: AXI-lite write of 1 to 0x00 bit0
//   status_rd    in   1   1-cycle pulse: AXI-lite read of 0x00 completed
//   data_length  in   32  number of samples (reg 0x10)
//   ap_start/ap_done/ap_idle out 1 each  status bits 0/1/2 of 0x00
//   tap_lock     out  1   1 = compute side owns tap RAM; AXI-lite tap access muxed off
//   ss_tvalid, ss_tlast in 1; ss_tdata in pDATA_WIDTH; ss_tready out 1
//   sm_tready    in   1;  sm_tvalid, sm_tlast out 1
//   tap_EN out 1; tap_A out pADDR_WIDTH     compute-side tap RAM read
//   data_EN out 1; data_WE out 4; data_A out pADDR_WIDTH; data_Di out pDATA_WIDTH
//   mac_en       out  1   accumulate tap_Do*data_Do this cycle
//   mac_clr      out  1   with mac_en: load product instead of adding (first term)
// BEHAVIOUR
//   Reset (async, immediate, also mid-operation): state IDLE, ap_idle=1, all other outputs 0, wptr=0, counters 0.
//   Addresses are byte addresses: index*4. bram11 read latency 1 cycle; writes take effect on the clock edge.
//   States: IDLE -> INIT -> WAIT_IN -> MAC -> DRAIN -> OUT -> (WAIT_IN | DONE) ; DONE -> IDLE.
//   IDLE: start_req -> INIT, ap_start=1, ap_idle=0, tap_lock=1. start_req outside IDLE ignored.
//   INIT: 11 cycles, data_EN=1, data_WE=4'hF, data_Di=0, data_A=0,4,..,40; wptr=0; ap_start cleared on exit.
//   WAIT_IN: ss_tready=1. On ss_tvalid&ss_tready (cycle T): data_WE=4'hF, data_A=4*wptr,
//     data_Di=ss_tdata, capture ss_tlast; -> MAC. ss_tready=0 in every other state.
//   MAC: k=0..10 on cycles T+1..T+11: tap_EN=data_EN=1, WE=0, tap_A=4*k,
//     data_A=4*((wptr-k) mod 11). mac_en high T+2..T+12 (1-cycle delay), mac_clr only at T+2.
//   DRAIN: T+12, last mac_en. OUT: sm_tvalid=1 from T+13, held with sm_tlast stable until sm_tready.
//   sm_tlast = captured ss_tlast OR (out_cnt == data_length-1); data_length==0: only ss_tlast.
//   OUT handshake: wptr = (wptr==10)?0:wptr+1, out_cnt++; sm_tlast -> DONE else WAIT_IN.
//   Throughput with sm_tready=1: one sample per 14 cycles. Backpressure: no new input accepted in OUT.
//   DONE (1 cycle): ap_done=1, ap_idle=1, tap_lock=0 -> IDLE. ap_done cleared only by status_rd
//     (status_rd coincident with setting: set wins). Next start_req re-runs INIT; out_cnt cleared.
//   wptr arithmetic: 4-bit, modulo 11, never reaches 11.
// TESTING (bench: fir_seq_ctrl + two bram11 + behavioural MAC, coef 0,-10,-9,23,56,63,56,23,-9,-10,0)
//   Reset: after release ap_idle=1, ap_start=ap_done=0, ss_tready=0, sm_tvalid=0, tap_lock=0.
//   data_length=3, start, samples 1,2,3: INIT writes 0 to A=0..40; sample2 data_A read seq 4,0,40,36..8; outputs 0,-10,-29.
//   sm_tready low 5 cycles on sample 1: sm_tvalid/sm_tdata held, ss_tready stays 0, no data_WE.
//   12 samples: 12th sample written at data_A=0 (wrap), output matches golden FIR.
//   start_req mid-run ignored; after 3rd output with sm_tlast=1: ap_done=1, ap_idle=1; status_rd clears ap_done.
//   axis_rst_n low during MAC: all outputs return to reset values in same cycle; restart produces correct outputs.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fir_seq_ctrl
//   Control sequencer for an 11-tap FIR engine. It runs the ap_start/ap_done/
//   ap_idle protocol, the AXI-Stream input and output handshakes, and all
//   compute-side addressing of the tap RAM and the circular data RAM. The
//   multiply-accumulate datapath sits outside this block and follows the
//   mac_en/mac_clr strobes.
//
//   Per-run flow:
//     IDLE    wait for start_req
//     INIT    zero the 11 data RAM entries (one write per cycle)
//     WAIT_IN accept one input sample and write it at the circular pointer
//     MAC     11 tap/data reads, newest sample first
//     DRAIN   last accumulate (RAM read latency is one cycle)
//     OUT     present the result until the sink accepts it
//     DONE    one cycle, then back to IDLE
//
// Ports
//   axis_clk, axis_rst_n     clock, asynchronous active-low reset
//   start_req, status_rd     1-cycle pulses from the AXI-lite register side
//   data_length              number of samples in the run (0 = ss_tlast only)
//   ap_start/ap_done/ap_idle status bits 0/1/2 of register 0x00
//   tap_lock                 compute side owns the tap RAM
//   ss_*                     input stream (slave)
//   sm_tvalid/sm_tlast/sm_tready  output stream control (data comes from MAC)
//   tap_EN/tap_A             tap RAM read port (byte address)
//   data_EN/WE/A/Di          data RAM port (byte address)
//   mac_en, mac_clr          accumulate strobe; mac_clr loads instead of adds
//   state_dbg                current FSM state, for debug and checkers
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised it stays high, with its payload and
// tlast stable, until that edge. Ready never depends combinationally on valid.
// -----------------------------------------------------------------------------
module fir_seq_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start_req,
  input  logic                   status_rd,
  input  logic [31:0]            data_length,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   tap_lock,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic                   mac_en,
  output logic                   mac_clr,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_WAIT_IN = 3'd2,
    S_MAC     = 3'd3,
    S_DRAIN   = 3'd4,
    S_OUT     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [3:0] DEPTH    = 4'(Tape_Num);
  localparam logic [3:0] LAST_IDX = 4'(Tape_Num - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;       // INIT entry index / MAC tap index
  logic [3:0]  wptr;      // slot of the newest sample, 0..Tape_Num-1
  logic [31:0] out_cnt;   // outputs delivered in this run
  logic        tlast_q;   // ss_tlast captured with the current sample
  logic [3:0]  rd_idx;
  logic        len_hit;
  logic        last_flag;
  logic        in_hs;
  logic        out_hs;

  // Word index -> byte address.
  function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [3:0] idx);
    logic [pADDR_WIDTH-1:0] a;
    a      = '0;
    a[5:2] = idx;
    return a;
  endfunction

  // Data slot holding x[n-k]: (wptr - k) mod Tape_Num. The wrap branch is
  // evaluated mod 16 but its true value always lies in 1..Tape_Num-1.
  assign rd_idx = (wptr >= cnt) ? (wptr - cnt) : (wptr + DEPTH - cnt);

  // A zero data_length disables the count limit; only ss_tlast ends the run.
  assign len_hit   = (data_length != 32'd0) && (out_cnt == data_length - 32'd1);
  assign last_flag = tlast_q | len_hit;

  assign in_hs  = (state == S_WAIT_IN) && ss_tvalid;
  assign out_hs = (state == S_OUT) && sm_tready;

  // Status bits are pure decodes of the state so reset clears them at once.
  assign ap_start  = (state == S_INIT);
  assign ap_idle   = (state == S_IDLE) || (state == S_DONE);
  assign tap_lock  = !ap_idle;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      wptr    <= 4'd0;
      out_cnt <= 32'd0;
      tlast_q <= 1'b0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      ap_done <= 1'b0;
    end else begin
      state <= state_nx;

      // Counter restarts on every state change and runs inside INIT and MAC.
      if (state_nx != state) begin
        cnt <= 4'd0;
      end else if ((state == S_INIT) || (state == S_MAC)) begin
        cnt <= cnt + 4'd1;
      end

      // RAM data comes back one cycle after the read, so the strobes lag
      // the MAC address phase by one cycle; the first term loads.
      mac_en  <= (state == S_MAC);
      mac_clr <= (state == S_MAC) && (cnt == 4'd0);

      if ((state == S_IDLE) && start_req) begin
        wptr    <= 4'd0;
        out_cnt <= 32'd0;
        tlast_q <= 1'b0;
      end

      if (in_hs) begin
        tlast_q <= ss_tlast;
      end

      if (out_hs) begin
        wptr    <= (wptr == LAST_IDX) ? 4'd0 : wptr + 4'd1;
        out_cnt <= out_cnt + 32'd1;
      end

      // Sticky done: a status read on the setting edge loses to the set.
      if (out_hs && last_flag) begin
        ap_done <= 1'b1;
      end else if (status_rd) begin
        ap_done <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and RAM / stream outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = '0;

    case (state)
      S_IDLE: begin
        if (start_req) begin
          state_nx = S_INIT;
        end
      end

      S_INIT: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = byte_addr(cnt);
        if (cnt == LAST_IDX) begin
          state_nx = S_WAIT_IN;
        end
      end

      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN  = 1'b1;
          data_WE  = 4'hF;
          data_A   = byte_addr(wptr);
          data_Di  = ss_tdata;
          state_nx = S_MAC;
        end
      end

      S_MAC: begin
        tap_EN  = 1'b1;
        data_EN = 1'b1;
        tap_A   = byte_addr(cnt);
        data_A  = byte_addr(rd_idx);
        if (cnt == LAST_IDX) begin
          state_nx = S_DRAIN;
        end
      end

      S_DRAIN: begin
        state_nx = S_OUT;
      end

      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last_flag;
        if (sm_tready) begin
          state_nx = last_flag ? S_DONE : S_WAIT_IN;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_seq_ctrl
//   Bench for fir_seq_ctrl with two behavioural bram11 models (1-cycle read
//   latency) and a behavioural multiply-accumulate stage. Expected outputs come
//   from a direct FIR convolution over the sample history of each run.
// -----------------------------------------------------------------------------
module tb_fir_seq_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic axis_rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic        start_req = 1'b0;
  logic        status_rd = 1'b0;
  logic [31:0] data_length = 32'd3;
  logic        ap_start, ap_done, ap_idle, tap_lock;
  logic        ss_tvalid = 1'b0;
  logic        ss_tlast = 1'b0;
  logic [31:0] ss_tdata = 32'd0;
  logic        ss_tready;
  logic        sm_tready = 1'b0;
  logic        sm_tvalid, sm_tlast;
  logic        tap_EN, data_EN;
  logic [11:0] tap_A, data_A;
  logic [3:0]  data_WE;
  logic [31:0] data_Di;
  logic        mac_en, mac_clr;
  logic [2:0]  state_dbg;

  fir_seq_ctrl dut (
    .axis_clk    (clk),
    .axis_rst_n  (axis_rst_n),
    .start_req   (start_req),
    .status_rd   (status_rd),
    .data_length (data_length),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .tap_lock    (tap_lock),
    .ss_tvalid   (ss_tvalid),
    .ss_tlast    (ss_tlast),
    .ss_tdata    (ss_tdata),
    .ss_tready   (ss_tready),
    .sm_tready   (sm_tready),
    .sm_tvalid   (sm_tvalid),
    .sm_tlast    (sm_tlast),
    .tap_EN      (tap_EN),
    .tap_A       (tap_A),
    .data_EN     (data_EN),
    .data_WE     (data_WE),
    .data_A      (data_A),
    .data_Di     (data_Di),
    .mac_en      (mac_en),
    .mac_clr     (mac_clr),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // RAMs and MAC datapath
  // ---------------------------------------------------------------------------
  int coef[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  logic signed [31:0] tap_mem  [0:15];
  logic signed [31:0] data_mem [0:15];
  logic signed [31:0] tap_Do, data_Do, acc;

  initial begin
    for (int k = 0; k < 16; k++) tap_mem[k] = (k < 11) ? coef[k] : 0;
  end

  always @(posedge clk) begin
    if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];
    if (data_EN) begin
      if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
      data_Do <= data_mem[data_A[5:2]];
    end
    if (mac_en) acc <= mac_clr ? (tap_Do * data_Do) : (acc + tap_Do * data_Do);
  end

  // ---------------------------------------------------------------------------
  // Bus monitors (sampled mid-cycle)
  // ---------------------------------------------------------------------------
  logic [31:0] wr_a_q[$];
  logic [31:0] rd_a_q[$];
  int          acc_cyc_q[$];

  always @(negedge clk) begin
    if (ss_tvalid && ss_tready) acc_cyc_q.push_back(cyc);
    if (data_EN && data_WE == 4'hF) wr_a_q.push_back(32'(data_A));
    if (tap_EN) rd_a_q.push_back(32'(data_A));
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, got no event, expected one (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic do_start(input bit check_init);
    start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    if (check_init) begin
      chk1("start_ap_start", ap_start, 1'b1);
      chk1("start_ap_idle", ap_idle, 1'b0);
      chk1("start_tap_lock", tap_lock, 1'b1);
      for (int i = 0; i < 11; i++) begin
        chk1("init_data_en", data_EN, 1'b1);
        chk32("init_data_we", 32'(data_WE), 32'hF);
        chk32("init_data_a", 32'(data_A), 32'(4 * i));
        chk32("init_data_di", data_Di, 32'd0);
        @(posedge clk); #1;
      end
    end else begin
      repeat (11) begin @(posedge clk); #1; end
    end
    chk1("init_exit_ap_start", ap_start, 1'b0);
    chk1("init_exit_ss_tready", ss_tready, 1'b1);
  endtask

  task automatic send_sample(input logic [31:0] d, input logic l);
    int n = 0;
    ss_tdata  = d;
    ss_tlast  = l;
    ss_tvalid = 1'b1;
    while (!ss_tready && n < 200) begin @(posedge clk); #1; n++; end
    if (!ss_tready) begin
      fail_now("in_timeout");
      ss_tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
    ss_tdata  = $urandom;
  endtask

  task automatic recv_output(input int stall, input bit sr_at_hs);
    int n = 0;
    logic [31:0] held_d;
    logic        held_l;
    sm_tready = 1'b0;
    while (!sm_tvalid && n < 200) begin @(posedge clk); #1; n++; end
    if (!sm_tvalid) begin
      fail_now("out_timeout");
      return;
    end
    held_d = acc;
    held_l = sm_tlast;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk1("stall_tvalid", sm_tvalid, 1'b1);
      chk32("stall_tdata", acc, held_d);
      chk1("stall_tlast", sm_tlast, held_l);
      chk1("stall_ss_tready", ss_tready, 1'b0);
      chk32("stall_data_we", 32'(data_WE), 32'd0);
    end
    if (exp_q.size() == 0) begin
      fail_now("out_unexpected");
    end else begin
      chk32("out_data", acc, exp_q.pop_front());
      chk1("out_last", sm_tlast, exp_last_q.pop_front());
    end
    sm_tready = 1'b1;
    status_rd = sr_at_hs;
    @(posedge clk); #1;
    sm_tready = 1'b0;
    status_rd = 1'b0;
  endtask

  // Entered in the DONE cycle right after the final output handshake.
  task automatic end_checks();
    chk1("done_ap_done", ap_done, 1'b1);
    chk1("done_ap_idle", ap_idle, 1'b1);
    chk1("done_tap_lock", tap_lock, 1'b0);
    chk1("done_sm_tvalid", sm_tvalid, 1'b0);
    @(posedge clk); #1;
    chk1("idle_ap_done_sticky", ap_done, 1'b1);
    chk1("idle_ap_idle", ap_idle, 1'b1);
    status_rd = 1'b1;
    @(posedge clk); #1;
    status_rd = 1'b0;
    chk1("status_rd_clear", ap_done, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: samples 1,2,3 with data_length 3
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] sample;
    logic        last_in;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t vecs[3];

  task automatic run_table();
    int exp_rd[11] = '{4, 0, 40, 36, 32, 28, 24, 20, 16, 12, 8};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vecs[i].exp_data);
      exp_last_q.push_back(vecs[i].exp_last);
      if (i == 1) rd_a_q.delete();
      send_sample(vecs[i].sample, vecs[i].last_in);
      chk32("tbl_wr_addr", wr_a_q[$], 32'(4 * i));
      if (i == 1) begin
        // A start request during the run must be ignored.
        start_req = 1'b1;
        @(posedge clk); #1;
        start_req = 1'b0;
        chk1("midrun_ap_start", ap_start, 1'b0);
        chk1("midrun_tap_lock", tap_lock, 1'b1);
      end
      recv_output(vecs[i].stall, 1'b0);
      if (i == 1) begin
        chk32("rd_seq_len", 32'(rd_a_q.size()), 32'd11);
        for (int k = 0; k < 11 && k < rd_a_q.size(); k++)
          chk32("rd_seq_addr", rd_a_q[k], 32'(exp_rd[k]));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomised stream against the convolution model
  // ---------------------------------------------------------------------------
  task automatic run_stream(input int n, input int tlast_at, input int max_stall,
                            input bit sr_at_last);
    int   hist[$];
    int   x;
    int   y;
    logic el;
    for (int i = 0; i < n; i++) begin
      x = int'($urandom_range(0, 2000)) - 1000;
      hist.push_back(x);
      y = 0;
      for (int k = 0; k < 11; k++)
        if (i - k >= 0) y += coef[k] * hist[i - k];
      el = (i == tlast_at) || (data_length != 32'd0 && i == int'(data_length) - 1);
      exp_q.push_back(32'(y));
      exp_last_q.push_back(el);
      send_sample(32'(x), i == tlast_at);
      chk32("wr_addr", wr_a_q[$], 32'(4 * (i % 11)));
      if (max_stall == 0 && i > 0)
        chk32("accept_gap", 32'(acc_cyc_q[$] - acc_cyc_q[$-1]), 32'd14);
      recv_output((max_stall == 0) ? 0 : int'($urandom_range(0, max_stall)),
                  sr_at_last && el);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    vecs[0] = '{32'd1, 1'b0, 5, 32'd0,          1'b0};
    vecs[1] = '{32'd2, 1'b0, 0, 32'hFFFF_FFF6,  1'b0};
    vecs[2] = '{32'd3, 1'b0, 0, 32'hFFFF_FFE3,  1'b1};

    repeat (3) @(posedge clk);
    #1;
    axis_rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rst_ap_idle", ap_idle, 1'b1);
    chk1("rst_ap_start", ap_start, 1'b0);
    chk1("rst_ap_done", ap_done, 1'b0);
    chk1("rst_ss_tready", ss_tready, 1'b0);
    chk1("rst_sm_tvalid", sm_tvalid, 1'b0);
    chk1("rst_tap_lock", tap_lock, 1'b0);
    chk1("rst_mac_en", mac_en, 1'b0);
    chk1("rst_data_en", data_EN, 1'b0);

    // Directed run with backpressure, mid-run start and done/status handling.
    data_length = 32'd3;
    do_start(1'b1);
    run_table();
    end_checks();

    // Twelve samples at full rate: write pointer wraps to slot 0.
    data_length = 32'd12;
    do_start(1'b0);
    run_stream(12, -1, 0, 1'b0);
    end_checks();

    // Random length with random output backpressure.
    data_length = $urandom_range(4, 9);
    do_start(1'b0);
    run_stream(int'(data_length), -1, 3, 1'b0);
    end_checks();

    // data_length 0: only ss_tlast ends the run; status read on the set edge.
    data_length = 32'd0;
    n = $urandom_range(3, 6);
    do_start(1'b0);
    run_stream(n, n - 1, 2, 1'b1);
    end_checks();

    // Early ss_tlast ends the run before data_length is reached.
    data_length = 32'd20;
    do_start(1'b0);
    run_stream(6, 5, 1, 1'b0);
    end_checks();

    // Asynchronous reset in the middle of MAC, then a clean rerun.
    data_length = 32'd3;
    do_start(1'b0);
    send_sample(32'd7, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk1("pre_rst_mac_en", mac_en, 1'b1);
    #2;
    axis_rst_n = 1'b0;
    #1;
    chk1("midrst_ap_idle", ap_idle, 1'b1);
    chk1("midrst_ap_start", ap_start, 1'b0);
    chk1("midrst_ap_done", ap_done, 1'b0);
    chk1("midrst_tap_lock", tap_lock, 1'b0);
    chk1("midrst_mac_en", mac_en, 1'b0);
    chk1("midrst_tap_en", tap_EN, 1'b0);
    chk1("midrst_data_en", data_EN, 1'b0);
    chk1("midrst_ss_tready", ss_tready, 1'b0);
    chk1("midrst_sm_tvalid", sm_tvalid, 1'b0);
    @(posedge clk); #1;
    axis_rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_last_q.delete();
    do_start(1'b0);
    run_table();
    end_checks();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
